// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, baud divisor helper and frame length.
// Frame length grows to 11 bits when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    RD_LAT = 2'd2,
    SEND   = 2'd3
  } uart_state_e;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_LEN = 11;
`else
  localparam int unsigned FRAME_LEN = 10;
`endif

  // Clock cycles per bit; the fractional remainder is dropped.
  function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                               input int unsigned bps);
    return clk_freq / bps;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud counter: runs 0..BAUD_CNT_MAX-1, held at 0 while restart is high,
// bit_end marks the last cycle of each bit period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_CNT_MAX = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int unsigned CNT_W = clog2_min1(BAUD_CNT_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit_end_q, bit_end_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || (cnt_q == CNT_W'(BAUD_CNT_MAX - 1))) begin
      cnt_d = '0;
    end
    bit_end_d = (cnt_d == CNT_W'(BAUD_CNT_MAX - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      bit_end_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_end_q <= bit_end_d;
    end
  end

  assign bit_end = bit_end_q;

endmodule

// File: rtl/uart_transmitter.sv
// Serialises FIFO words onto a UART line, 8N1, most-significant byte first.
// UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned UART_BPS      = 9600,
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned FIFO_RD_WIDTH = 32,
  parameter int unsigned FIFO_RD_BYTE  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FIFO_RD_WIDTH-1:0] fifo_rd_data,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  output logic                     tx,
  output logic                     busy
);

  localparam int unsigned BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam int unsigned BIT_W        = 4;
  localparam int unsigned BYTE_W       = clog2_min1(FIFO_RD_BYTE);

  uart_state_e              state_q, state_d;
  logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]        byte_cnt_q, byte_cnt_d;
  logic [FIFO_RD_WIDTH-1:0] word_q, word_d;
  logic                     tx_q, tx_d;
  logic                     rd_en_q, rd_en_d;
  logic                     busy_q, busy_d;
  logic                     baud_restart;
  logic                     bit_end;

  // Line level for frame position idx of byte b.
  function automatic logic frame_bit(input logic [7:0] b, input logic [BIT_W-1:0] idx);
    if (idx == BIT_W'(0)) begin
      return 1'b0;
    end else if (idx <= BIT_W'(8)) begin
      return b[3'(idx - BIT_W'(1))];
`ifdef UART_TX_PARITY_EN
    end else if (idx == BIT_W'(9)) begin
      return ^b;
`endif
    end else begin
      return 1'b1;
    end
  endfunction

  assign baud_restart = (state_q != SEND);

  uart_baud_gen #(
    .BAUD_CNT_MAX(BAUD_CNT_MAX)
  ) u_baud_gen (
    .clk    (clk),
    .rst    (rst),
    .restart(baud_restart),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        state_d = RD_LAT;
      end
      RD_LAT: begin
        word_d     = fifo_rd_data;
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
        state_d    = SEND;
      end
      SEND: begin
        if (bit_end) begin
          if (bit_cnt_q == BIT_W'(FRAME_LEN - 1)) begin
            bit_cnt_d = '0;
            if (byte_cnt_q == BYTE_W'(FIFO_RD_BYTE - 1)) begin
              byte_cnt_d = '0;
              state_d    = fifo_empty ? IDLE : RD_REQ;
            end else begin
              // Next byte moves into the top lane of the shift word.
              byte_cnt_d = byte_cnt_q + BYTE_W'(1);
              word_d     = word_q << 8;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next-state view so they align with the state.
    rd_en_d = (state_d == RD_REQ);
    busy_d  = (state_d != IDLE);
    tx_d    = 1'b1;
    if (state_d == SEND) begin
      tx_d = frame_bit(word_d[FIFO_RD_WIDTH-1 -: 8], bit_cnt_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      tx_q       <= 1'b1;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      tx_q       <= tx_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
    end
  end

  assign tx         = tx_q;
  assign fifo_rd_en = rd_en_q;
  assign busy       = busy_q;

endmodule
